// File: rtl/vram_arbiter.sv
// Single-port, two-bank video RAM arbiter: video fetch has absolute priority, CPU uses req/ack.
// Optional 1-entry posted write buffer when VRAM_ARB_WRBUF_EN is defined.
module vram_arbiter #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vid_ce,
  input  logic [AW-1:0] vid_a,
  output logic [DW-1:0] vid_q_rb,
  output logic [DW-1:0] vid_q_gg,
  output logic          vid_rdy,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_d,
  input  logic [1:0]    cpu_wrb,
  input  logic          cpu_rsel,
  output logic [DW-1:0] cpu_q,
  output logic          cpu_ack,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic [1:0]    mem_we,
  input  logic [DW-1:0] mem_q_rb,
  input  logic [DW-1:0] mem_q_gg
);

  typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_RDWAIT, C_ACK} cstate_e;
  typedef enum logic [1:0] {K_NONE, K_VID, K_CRD, K_CWR} kind_e;

  cstate_e         cst_q;
  kind_e           st1_q, st2_q;
  logic            vid_pend_q;
  logic [AW-1:0]   vid_a_q;
  logic            hold_q;
  logic [AW-1:0]   mem_a_q;
  logic [DW-1:0]   mem_d_q;
  logic [1:0]      mem_we_q;
  logic [DW-1:0]   vid_rb_q, vid_gg_q, cpu_q_q;
  logic            vid_rdy_q, cpu_ack_q;

`ifdef VRAM_ARB_WRBUF_EN
  localparam bit WrBuf = 1'b1;
  logic            wb_vld_q;
  logic [AW-1:0]   wb_a_q;
  logic [DW-1:0]   wb_d_q;
  logic [1:0]      wb_wrb_q;
`else
  localparam bit WrBuf = 1'b0;
  logic            wb_vld_q;
  assign wb_vld_q = 1'b0;
`endif

  logic vid_go, buf_wr, cpu_go, take;

  // Slot arbitration: pending video, then buffer drain, then the CPU access in C_ISSUE.
  always_comb begin
    vid_go = vid_pend_q;
    buf_wr = WrBuf && (cst_q == C_ISSUE) && cpu_we;
    cpu_go = !vid_pend_q && !wb_vld_q && (cst_q == C_ISSUE) && !buf_wr;
    take   = (cst_q == C_IDLE) && cpu_req && !hold_q && !(WrBuf && cpu_we && wb_vld_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cst_q      <= C_IDLE;
      st1_q      <= K_NONE;
      st2_q      <= K_NONE;
      vid_pend_q <= 1'b0;
      vid_a_q    <= '0;
      hold_q     <= 1'b0;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
      mem_we_q   <= 2'b00;
      vid_rb_q   <= '0;
      vid_gg_q   <= '0;
      cpu_q_q    <= '0;
      vid_rdy_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
`ifdef VRAM_ARB_WRBUF_EN
      wb_vld_q   <= 1'b0;
      wb_a_q     <= '0;
      wb_d_q     <= '0;
      wb_wrb_q   <= 2'b00;
`endif
    end else begin
      mem_we_q  <= 2'b00;
      vid_rdy_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      hold_q    <= 1'b0;
      st1_q     <= K_NONE;
      st2_q     <= st1_q;

      // A strobe arriving while one is pending overwrites the address.
      if (vid_ce) begin
        vid_pend_q <= 1'b1;
        vid_a_q    <= vid_a;
      end else if (vid_go) begin
        vid_pend_q <= 1'b0;
      end

      if (vid_go) begin
        mem_a_q <= vid_a_q;
        st1_q   <= K_VID;
      end
`ifdef VRAM_ARB_WRBUF_EN
      else if (wb_vld_q) begin
        mem_a_q  <= wb_a_q;
        mem_d_q  <= wb_d_q;
        mem_we_q <= wb_wrb_q;
        wb_vld_q <= 1'b0;
      end
`endif
      else if (cpu_go) begin
        mem_a_q  <= cpu_a;
        mem_d_q  <= cpu_d;
        mem_we_q <= cpu_we ? cpu_wrb : 2'b00;
        st1_q    <= cpu_we ? K_CWR : K_CRD;
      end

      if (st2_q == K_VID) begin
        vid_rb_q  <= mem_q_rb;
        vid_gg_q  <= mem_q_gg;
        vid_rdy_q <= 1'b1;
      end

      case (cst_q)
        C_IDLE: if (take) cst_q <= C_ISSUE;
        C_ISSUE: begin
          if (cpu_go) begin
            cst_q <= C_RDWAIT;
          end
`ifdef VRAM_ARB_WRBUF_EN
          else if (buf_wr) begin
            wb_vld_q  <= 1'b1;
            wb_a_q    <= cpu_a;
            wb_d_q    <= cpu_d;
            wb_wrb_q  <= cpu_wrb;
            cpu_ack_q <= 1'b1;
            cst_q     <= C_ACK;
          end
`endif
        end
        C_RDWAIT: begin
          if (st1_q == K_CWR) begin
            cpu_ack_q <= 1'b1;
            cst_q     <= C_ACK;
          end else if (st2_q == K_CRD) begin
            cpu_q_q   <= cpu_rsel ? mem_q_gg : mem_q_rb;
            cpu_ack_q <= 1'b1;
            cst_q     <= C_ACK;
          end
        end
        C_ACK: begin
          cst_q  <= C_IDLE;
          hold_q <= 1'b1;
        end
        default: cst_q <= C_IDLE;
      endcase
    end
  end

  assign vid_q_rb = vid_rb_q;
  assign vid_q_gg = vid_gg_q;
  assign vid_rdy  = vid_rdy_q;
  assign cpu_q    = cpu_q_q;
  assign cpu_ack  = cpu_ack_q;
  assign mem_a    = mem_a_q;
  assign mem_d    = mem_d_q;
  assign mem_we   = mem_we_q;

endmodule
